// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine and CPU/bus arbiter with NES 513/514-cycle stall
// Ports:
//   clk, rst            clock (one CPU cycle per edge), synchronous active-high reset
//   cpu_addr/d_out/we   CPU bus request, passed through while idle
//   cpu_d_in            read data to CPU, always the system bus read data
//   cpu_halt            holds the CPU (RDY low) while a transfer is in progress
//   bus_addr/d_out/we   system bus request, from the CPU or the DMA engine
//   bus_d_in            system bus read data
//   dma_busy            high in every non-idle state
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_d_in,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_d_out,
    output logic        bus_we,
    input  logic [7:0]  bus_d_in,
    output logic        dma_busy
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
    state_t state, next;
    logic [7:0] page, idx, latch;
    logic par, idle, trig, last;
    assign idle = state == IDLE;
    assign trig = idle && cpu_we && cpu_addr == DMA_REG_ADDR;
    assign last = idx == 8'(XFER_LEN - 1);
    assign cpu_d_in = bus_d_in;
    assign cpu_halt = !idle;
    assign dma_busy = !idle;
    assign bus_addr = state == READ ? {page, idx} : state == WRITE ? OAM_DATA_ADDR : cpu_addr;
    assign bus_d_out = idle ? cpu_d_out : latch;
    assign bus_we = idle ? cpu_we : state == WRITE;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = trig ? HALT : IDLE;
            // odd parity in the halt cycle costs one extra alignment cycle
            HALT:    next = par ? ALIGN : READ;
            ALIGN:   next = READ;
            READ:    next = WRITE;
            WRITE:   next = last ? IDLE : READ;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            page  <= '0;
            idx   <= '0;
            latch <= '0;
            par   <= 1'b0;
        end else begin
            state <= next;
            par   <= ~par;
            if (trig) begin
                page <= cpu_d_out;
                idx  <= '0;
            end
            if (state == READ) latch <= bus_d_in;
            if (state == WRITE && !last) idx <= idx + 8'd1;
        end
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma
module tb_oam_dma;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic [7:0]  cpu_d_in;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d_out;
    logic        bus_we;
    logic [7:0]  bus_d_in;
    logic        dma_busy;

    oam_dma dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_we(cpu_we),
        .cpu_d_in(cpu_d_in), .cpu_halt(cpu_halt), .bus_addr(bus_addr), .bus_d_out(bus_d_out),
        .bus_we(bus_we), .bus_d_in(bus_d_in), .dma_busy(dma_busy)
    );

    always #5 clk = ~clk;

    assign bus_d_in = bus_addr[7:0] ^ 8'hA5;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int hcnt = 0;
    int exp_first = 0;
    logic [7:0] exp_page = '0;
    logic [15:0] prev_addr = '0;
    logic [39:0] exp_q[$];
    int len_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            hcnt = 0;
        end else if (cpu_halt) begin
            hcnt++;
            if (hcnt == exp_first) chk("first_rd", {bus_we, bus_addr}, {1'b0, exp_page, 8'h00});
            if (bus_we) begin
                if (exp_q.size() == 0) chk("xfer_extra", 1, 0);
                else chk("xfer", {prev_addr, bus_addr, bus_d_out}, exp_q.pop_front());
            end
        end else if (hcnt != 0) begin
            if (len_q.size() == 0) chk("len_extra", 1, 0);
            else chk("halt_len", hcnt, len_q.pop_front());
            hcnt = 0;
        end
        prev_addr = bus_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain transfer, 1: retrigger attempt while busy, 2: reset at idx $40
    task automatic dma(input logic [7:0] pg, input bit odd, input int mode);
        if (((cyc + 1) & 1) != int'(odd)) tick();
        exp_page = pg;
        exp_first = odd ? 3 : 2;
        cpu_addr = 16'h4014;
        cpu_d_out = pg;
        cpu_we = 1'b1;
        #1;
        chk("trig_pass", {cpu_halt, bus_we, bus_addr, bus_d_out}, {1'b0, 1'b1, 16'h4014, pg});
        len_q.push_back(odd ? 514 : 513);
        for (int i = 0; i < 256; i++) exp_q.push_back({pg, 8'(i), 16'h2004, 8'(i) ^ 8'hA5});
        tick();
        cpu_we = 1'b0;
        cpu_addr = 16'h8000;
        cpu_d_out = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if (mode == 1 && n == 20) begin
                cpu_we = 1'b1;
                cpu_addr = 16'h4014;
                cpu_d_out = 8'h07;
            end
            if (mode == 1 && n == 30) begin
                cpu_we = 1'b0;
                cpu_addr = 16'h8000;
            end
            if (mode == 2 && !bus_we && bus_addr == {pg, 8'h40}) begin
                rst = 1'b1;
                tick();
                chk("rst_abort", {cpu_halt, dma_busy, bus_we}, 3'b000);
                rst = 1'b0;
                exp_q.delete();
                len_q.delete();
                return;
            end
            if (!dma_busy) break;
            tick();
        end
        chk("done", dma_busy, 0);
        chk("pass_after", bus_addr, 16'h8000);
        tick();
        chk("drained", exp_q.size(), 0);
        chk("len_drained", len_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = '0;
        cpu_d_out = '0;
        cpu_we = 1'b0;
        tick();
        tick();
        chk("rst_halt", {cpu_halt, dma_busy}, 2'b00);
        rst = 1'b0;
        cpu_addr = 16'h0123;
        #1;
        chk("pt_rd", {cpu_halt, bus_we, bus_addr, cpu_d_in}, {1'b0, 1'b0, 16'h0123, 8'h86});
        tick();
        cpu_addr = 16'h0300;
        cpu_d_out = 8'h55;
        cpu_we = 1'b1;
        #1;
        chk("pt_wr", {cpu_halt, bus_we, bus_addr, bus_d_out}, {1'b0, 1'b1, 16'h0300, 8'h55});
        tick();
        cpu_we = 1'b0;
        dma(8'h02, 1'b0, 0);
        dma(8'h02, 1'b1, 0);
        dma(8'hFF, 1'b0, 0);
        dma(8'hFF, 1'b1, 0);
        dma(8'h03, 1'b1, 1);
        dma(8'h03, 1'b0, 1);
        dma(8'h04, 1'b0, 2);
        dma(8'h04, 1'b0, 0);
        dma(8'h05, 1'b1, 2);
        dma(8'h05, 1'b1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
